// File: rtl/wb_adc16_onehot_decoder_if.sv
// Stream/control bundle for wb_adc16_onehot_decoder.
// master: the controller that loads flag vectors and consumes (chip, lane) pairs.
// slave : the decoder itself.
interface wb_adc16_onehot_decoder_if #(
    parameter int N_CHIPS = 8,
    parameter int CNT_W   = 8
);
    logic [N_CHIPS*8-1:0] onehot_in;
    logic                 load;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_CHIPS-1:0]   chip_sel;
    logic [2:0]           lane_sel;
    logic                 done;
    logic [CNT_W-1:0]     emit_cnt;
    logic                 multi_err;

    modport master (
        output onehot_in, load, out_ready,
        input  busy, out_valid, chip_sel, lane_sel, done, emit_cnt, multi_err
    );

    modport slave (
        input  onehot_in, load, out_ready,
        output busy, out_valid, chip_sel, lane_sel, done, emit_cnt, multi_err
    );
endinterface

// File: rtl/wb_adc16_onehot_decoder.sv
// wb_adc16_onehot_decoder
// Walks a captured N_CHIPS*8 flag vector (bit i*8+l = chip i, lane l) and
// emits every set bit, lowest index first, as a (one-hot chip, lane) pair on
// a valid/ready stream.
// Optional macro WB_ADC16_ONEHOT_DECODER_STRICT_EN: keep only the lowest set
// lane of each chip at capture and raise sticky multi_err on any multi-hot
// chip byte. Without it every set bit is emitted and multi_err is tied 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for load; load captures onehot_in
// SCAN  | pick lowest pending bit; if nothing is pending, finish
// HOLD  | pair presented; wait for out_valid && out_ready
// FIN   | done pulse for this cycle, then back to IDLE
//
// The empty-vector check lives in SCAN so a zero load and the tail of a
// non-empty walk share one path: done always lands two cycles after the
// last accepted event (load or final handshake).
module wb_adc16_onehot_decoder #(
    parameter int N_CHIPS = 8,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wb_adc16_onehot_decoder_if.slave bus
);
    localparam int W = N_CHIPS * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       pending_q, pending_d;
    logic [W-1:0]       cur_mask_q, cur_mask_d;
    logic [N_CHIPS-1:0] chip_sel_q, chip_sel_d;
    logic [2:0]         lane_sel_q, lane_sel_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   emit_cnt_q, emit_cnt_d;

    logic [W-1:0]       cap_vec;
    logic [W-1:0]       low_mask;
    logic [N_CHIPS-1:0] low_chip;
    logic [2:0]         low_lane;

`ifdef WB_ADC16_ONEHOT_DECODER_STRICT_EN
    logic       cap_err;
    logic       multi_err_q;
    logic [7:0] byte_v;

    // Reduce each chip byte to its lowest set lane and flag multi-hot bytes.
    always_comb begin
        cap_vec = '0;
        cap_err = 1'b0;
        byte_v  = '0;
        for (int c = 0; c < N_CHIPS; c++) begin
            byte_v              = bus.onehot_in[c*8 +: 8];
            cap_vec[c*8 +: 8]   = byte_v & (~byte_v + 8'd1);
            if ((byte_v & (byte_v - 8'd1)) != 8'd0) begin
                cap_err = 1'b1;
            end
        end
    end

    // Sticky multi-hot flag, set only on an accepted load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_err_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.load && cap_err) begin
            multi_err_q <= 1'b1;
        end
    end

    assign bus.multi_err = multi_err_q;
`else
    assign cap_vec       = bus.onehot_in;
    assign bus.multi_err = 1'b0;
`endif

    // Priority pick of the lowest pending bit; descending loop so bit 0 wins.
    always_comb begin
        low_mask = '0;
        low_chip = '0;
        low_lane = '0;
        for (int j = W - 1; j >= 0; j--) begin
            if (pending_q[j]) begin
                low_mask          = '0;
                low_mask[j]       = 1'b1;
                low_chip          = '0;
                low_chip[j / 8]   = 1'b1;
                low_lane          = 3'(j % 8);
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cur_mask_d  = cur_mask_q;
        chip_sel_d  = chip_sel_q;
        lane_sel_d  = lane_sel_q;
        out_valid_d = out_valid_q;
        emit_cnt_d  = emit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    pending_d  = cap_vec;
                    emit_cnt_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pending_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    chip_sel_d  = low_chip;
                    lane_sel_d  = low_lane;
                    cur_mask_d  = low_mask;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    pending_d   = pending_q & ~cur_mask_q;
                    cur_mask_d  = '0;
                    if (emit_cnt_q != '1) begin
                        emit_cnt_d = emit_cnt_q + CNT_W'(1);
                    end
                    out_valid_d = 1'b0;
                    chip_sel_d  = '0;
                    lane_sel_d  = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards any walk in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            cur_mask_q  <= '0;
            chip_sel_q  <= '0;
            lane_sel_q  <= '0;
            out_valid_q <= 1'b0;
            emit_cnt_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            cur_mask_q  <= cur_mask_d;
            chip_sel_q  <= chip_sel_d;
            lane_sel_q  <= lane_sel_d;
            out_valid_q <= out_valid_d;
            emit_cnt_q  <= emit_cnt_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.out_valid = out_valid_q;
    assign bus.chip_sel  = chip_sel_q;
    assign bus.lane_sel  = lane_sel_q;
    assign bus.emit_cnt  = emit_cnt_q;
endmodule

// File: tb/tb_wb_adc16_onehot_decoder.sv
`timescale 1ns/1ps
module tb_wb_adc16_onehot_decoder;
    localparam int N_CHIPS = 8;
    localparam int CNT_W   = 8;
`ifdef WB_ADC16_ONEHOT_DECODER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_adc16_onehot_decoder_if #(.N_CHIPS(N_CHIPS), .CNT_W(CNT_W)) bus ();

    wb_adc16_onehot_decoder #(.N_CHIPS(N_CHIPS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] chip;
        logic [2:0] lane;
    } pair_t;

    pair_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] chip, input logic [2:0] lane);
        pair_t p;
        p.chip = chip;
        p.lane = lane;
        exp_q.push_back(p);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Load in cycle 0; returns at the start of cycle 1.
    task automatic start_load(input logic [63:0] v);
        @(posedge clk);
        #1;
        bus.onehot_in = v;
        bus.load      = 1'b1;
        @(posedge clk);
        #1;
        bus.load      = 1'b0;
    endtask

    // Cycle-by-cycle expectations for cycles 1..ncyc after a load.
    task automatic run_seq(input string tag, input int ncyc, input logic [31:0] vmask,
                           input int done_c, input int ready_from, input int reload_c);
        for (int c = 1; c <= ncyc; c++) begin
            bus.out_ready = (c >= ready_from);
            if (c == reload_c) begin
                bus.load      = 1'b1;
                bus.onehot_in = 64'h0000_0000_0000_FF00;
            end else begin
                bus.load = 1'b0;
            end
            smp();
            chk({tag, "_valid"}, bus.out_valid, vmask[c]);
            chk({tag, "_done"},  bus.done,      (c == done_c));
            chk({tag, "_busy"},  bus.busy,      (c <= done_c));
            nxt();
        end
        bus.load = 1'b0;
    endtask

    // Scoreboard monitor: pairs are compared on handshake, held pairs against
    // the queue head, and idle outputs must be zero.
    always @(negedge clk) begin
        pair_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pair: got chip=0x%0h lane=%0d expected none",
                             bus.chip_sel, bus.lane_sel);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_chip", bus.chip_sel, e.chip);
                    chk("pair_lane", bus.lane_sel, e.lane);
                end
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_hold: got chip=0x%0h lane=%0d expected none",
                             bus.chip_sel, bus.lane_sel);
                end else begin
                    chk("hold_pair", {bus.chip_sel, bus.lane_sel}, exp_q[0]);
                end
            end else begin
                chk("idle_sel_zero", {bus.chip_sel, bus.lane_sel}, 11'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.onehot_in = '0;
        bus.out_ready = 1'b0;
        #22;
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_valid",     bus.out_valid, 1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_emit",      bus.emit_cnt,  8'd0);
        chk("rst_multi_err", bus.multi_err, 1'b0);
        chk("rst_sel",       {bus.chip_sel, bus.lane_sel}, 11'd0);
        rst_n = 1'b1;

        // Empty vector: no pairs, done in cycle 2, busy cycles 1-2.
        start_load(64'd0);
        run_seq("t1", 4, 32'h0, 2, 1, 0);
        chk("t1_emit", bus.emit_cnt, 8'd0);

        // Single bit 21 -> chip 2, lane 5? No: 21 = chip 2 (0x04), lane 5.
        push(8'h04, 3'd5);
        start_load(64'd1 << 21);
        run_seq("t2", 6, 32'h4, 4, 1, 0);
        chk("t2_emit", bus.emit_cnt, 8'd1);

        // Bits {0,15,63}: ascending order, 2-cycle throughput.
        push(8'h01, 3'd0);
        push(8'h02, 3'd7);
        push(8'h80, 3'd7);
        start_load((64'd1 << 0) | (64'd1 << 15) | (64'd1 << 63));
        run_seq("t3", 10, 32'h54, 8, 1, 0);
        chk("t3_emit", bus.emit_cnt, 8'd3);

        // Reload attempt during HOLD is ignored.
        push(8'h01, 3'd1);
        push(8'h02, 3'd1);
        start_load((64'd1 << 1) | (64'd1 << 9));
        run_seq("t5", 12, 32'h5C, 8, 4, 2);
        chk("t5_emit",  bus.emit_cnt,  8'd2);
        chk("t5_queue", exp_q.size(),  0);
        chk("t5_multi_err", bus.multi_err, 1'b0);

        // Chip 3 byte 0b10100000 (bits 29, 31).
        push(8'h08, 3'd5);
        if (!STRICT) push(8'h08, 3'd7);
        start_load(64'hA0 << 24);
        run_seq("t6", 8, STRICT ? 32'h4 : 32'h14, STRICT ? 4 : 6, 1, 0);
        chk("t6_emit",      bus.emit_cnt,  STRICT ? 8'd1 : 8'd2);
        chk("t6_multi_err", bus.multi_err, STRICT);

        // Backpressure on bits {9,10}: ready low cycles 1-6, handshake in 7.
        push(8'h02, 3'd1);
        if (!STRICT) push(8'h02, 3'd2);
        start_load((64'd1 << 9) | (64'd1 << 10));
        run_seq("t4", 12, STRICT ? 32'hFC : 32'h2FC, STRICT ? 9 : 11, 7, 0);
        chk("t4_emit",      bus.emit_cnt,  STRICT ? 8'd1 : 8'd2);
        chk("t4_multi_err", bus.multi_err, STRICT);
        chk("t4_queue",     exp_q.size(),  0);

        // Async reset while a pair is held.
        bus.out_ready = 1'b0;
        push(8'h20, 3'd0);
        start_load(64'd1 << 40);
        nxt();
        smp();
        chk("t7_pre_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid",     bus.out_valid, 1'b0);
        chk("t7_rst_sel",       {bus.chip_sel, bus.lane_sel}, 11'd0);
        chk("t7_rst_busy",      bus.busy,      1'b0);
        chk("t7_rst_done",      bus.done,      1'b0);
        chk("t7_rst_emit",      bus.emit_cnt,  8'd0);
        chk("t7_rst_multi_err", bus.multi_err, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk("t7_no_done", bus.done, 1'b0);
            chk("t7_no_busy", bus.busy, 1'b0);
            nxt();
        end
        push(8'h80, 3'd7);
        start_load(64'd1 << 63);
        run_seq("t7", 6, 32'h4, 4, 1, 0);
        chk("t7_emit",  bus.emit_cnt, 8'd1);
        chk("t7_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
